// File: rtl/wave_meter.sv
// Purpose: measures period and min/max peaks of a sampled waveform using hysteresis rising-crossing detection.
// Latency: results register on the edge that samples the closing crossing; meas_valid is high for the following cycle.
// Backpressure: none; sample_en qualifies each input sample and the outputs cannot be stalled.
module wave_meter #(
  parameter int unsigned THRESH_HI = 192,
  parameter int unsigned THRESH_LO = 64,
  parameter int unsigned PERIOD_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          sample_in,
  input  logic                sample_en,
  output logic [PERIOD_W-1:0] period,
  output logic [7:0]          peak_max,
  output logic [7:0]          peak_min,
  output logic                meas_valid,
  output logic                locked,
  output logic                overflow
);

  localparam logic [7:0] HI = 8'(THRESH_HI);
  localparam logic [7:0] LO = 8'(THRESH_LO);

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] cnt;
  logic [7:0]          run_max;
  logic [7:0]          run_min;
  logic                win_open;

  logic                is_lo;
  logic                is_hi;
  logic                cnt_full;
  logic                rise;
  logic                timeout;

  assign is_lo    = (sample_in <= LO);
  assign is_hi    = (sample_in >= HI);
  assign cnt_full = &cnt;

  // State register; only the next-state logic decides whether an edge is enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEEK;
    else      state <= state_nxt;
  end

  // Next-state decode: hysteresis crossings and counter-saturation timeout.
  always_comb begin
    state_nxt = state;
    rise      = 1'b0;
    timeout   = 1'b0;
    if (sample_en) begin
      case (state)
        SEEK: begin
          if (is_lo) state_nxt = LOW;
        end
        LOW: begin
          if (is_hi) begin
            rise      = 1'b1;
            state_nxt = HIGH;
          end else if (cnt_full) begin
            timeout = 1'b1;
          end
        end
        HIGH: begin
          if (is_lo) state_nxt = LOW;
          // Nothing seen in HIGH is a crossing, so a full counter always times out.
          if (cnt_full) timeout = 1'b1;
        end
        default: state_nxt = SEEK;
      endcase
      if (timeout) state_nxt = SEEK;
    end
  end

  // Window counter, running extremes and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      run_max    <= 8'h00;
      run_min    <= 8'hFF;
      win_open   <= 1'b0;
      period     <= '0;
      peak_max   <= 8'h00;
      peak_min   <= 8'hFF;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise) begin
        // The crossing sample starts the new window and is excluded from the one it closes.
        cnt      <= PERIOD_W'(1);
        run_max  <= sample_in;
        run_min  <= sample_in;
        win_open <= 1'b1;
        if (win_open) begin
          period     <= cnt;
          peak_max   <= run_max;
          peak_min   <= run_min;
          meas_valid <= 1'b1;
          locked     <= 1'b1;
          overflow   <= 1'b0;
        end
      end else if (timeout) begin
        // Period too long to count: drop the window, keep the last results.
        cnt      <= '0;
        win_open <= 1'b0;
        overflow <= 1'b1;
        locked   <= 1'b0;
      end else if (sample_en && state != SEEK) begin
        cnt <= cnt + PERIOD_W'(1);
        if (sample_in > run_max) run_max <= sample_in;
        if (sample_in < run_min) run_min <= sample_in;
      end
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
// Purpose: directed scoreboard bench for wave_meter (main 16-bit instance plus an 8-bit counter instance).
// Latency: expected results are queued at stimulus time and popped by a negedge monitor on meas_valid.
// Backpressure: not applicable; the bench drives sample_en directly.
module tb_wave_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_en;

  logic [15:0] period;
  logic [7:0]  peak_max, peak_min;
  logic        meas_valid, locked, overflow;

  logic [7:0]  period8;
  logic [7:0]  peak_max8, peak_min8;
  logic        meas_valid8, locked8, overflow8;

  int checks = 0;
  int errors = 0;
  int mv8_cnt = 0;

  typedef struct {
    int p;
    int mx;
    int mn;
  } exp_t;

  exp_t expq[$];

  wave_meter #(.THRESH_HI(192), .THRESH_LO(64), .PERIOD_W(16)) u_dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_en(sample_en),
    .period(period), .peak_max(peak_max), .peak_min(peak_min),
    .meas_valid(meas_valid), .locked(locked), .overflow(overflow)
  );

  wave_meter #(.THRESH_HI(192), .THRESH_LO(64), .PERIOD_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_en(sample_en),
    .period(period8), .peak_max(peak_max8), .peak_min(peak_min8),
    .meas_valid(meas_valid8), .locked(locked8), .overflow(overflow8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int p, input int mx, input int mn);
    exp_t e;
    e.p = p;
    e.mx = mx;
    e.mn = mn;
    expq.push_back(e);
  endtask

  task automatic step(input logic [7:0] s, input logic en);
    sample_in = s;
    sample_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'd0, 1'b0);
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Scoreboard monitor: every meas_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b1 && meas_valid === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas: got period %0d max %0d min %0d, expected no pulse",
                 period, peak_max, peak_min);
      end else begin
        e = expq.pop_front();
        chk("meas_period", 32'(period), e.p);
        chk("meas_peak_max", 32'(peak_max), e.mx);
        chk("meas_peak_min", 32'(peak_min), e.mn);
        chk("meas_locked", 32'(locked), 1);
        chk("meas_overflow", 32'(overflow), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && meas_valid8 === 1'b1) mv8_cnt++;
  end

  initial begin
    int base;
    rst = 1'b0;
    sample_in = 8'd0;
    sample_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", 32'(period), 0);
    chk("rst_peak_max", 32'(peak_max), 0);
    chk("rst_peak_min", 32'(peak_min), 32'hFF);
    chk("rst_meas_valid", 32'(meas_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b1;

    // Sawtooth 0..255: four crossings of 192 give three measurements.
    pulse_rst();
    for (int k = 0; k < 3; k++) push(256, 255, 0);
    for (int p = 0; p < 3; p++)
      for (int v = 0; v < 256; v++) step(8'(v), 1'b1);
    for (int v = 0; v <= 192; v++) step(8'(v), 1'b1);
    idle(2);
    chk("saw_locked", 32'(locked), 1);

    // Triangle with every other edge disabled; disabled edges carry inverted junk.
    pulse_rst();
    for (int k = 0; k < 2; k++) push(510, 255, 0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 510; i++) begin
        step(8'((i <= 255) ? i : 510 - i), 1'b1);
        step(~8'((i <= 255) ? i : 510 - i), 1'b0);
      end
    for (int v = 0; v <= 192; v++) begin
      step(8'(v), 1'b1);
      step(~8'(v), 1'b0);
    end
    idle(2);

    // Rect 50 low / 50 high.
    pulse_rst();
    for (int k = 0; k < 3; k++) push(100, 255, 0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 50; i++) step(8'd0, 1'b1);
      for (int i = 0; i < 50; i++) step(8'd255, 1'b1);
    end
    for (int i = 0; i < 50; i++) step(8'd0, 1'b1);
    step(8'd255, 1'b1);
    idle(2);

    // Noise around THRESH_HI while HIGH must not add crossings: period 31.
    pulse_rst();
    for (int k = 0; k < 3; k++) push(31, 255, 0);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 20; i++) step(8'd0, 1'b1);
      step(8'd255, 1'b1);
      for (int i = 0; i < 5; i++) begin
        step(8'd190, 1'b1);
        step(8'd194, 1'b1);
      end
    end
    idle(2);
    chk("noise_locked", 32'(locked), 1);

    // Lock at period 20, then hold 128: the 8-bit counter times out on the 255th sample.
    pulse_rst();
    push(20, 255, 0);
    for (int i = 0; i < 10; i++) step(8'd0, 1'b1);
    for (int i = 0; i < 10; i++) step(8'd255, 1'b1);
    for (int i = 0; i < 10; i++) step(8'd0, 1'b1);
    step(8'd255, 1'b1);
    idle(2);
    chk("ovf8_lock_period", 32'(period8), 20);
    chk("ovf8_lock_locked", 32'(locked8), 1);
    base = mv8_cnt;
    for (int i = 0; i < 254; i++) step(8'd128, 1'b1);
    chk("ovf8_before", 32'(overflow8), 0);
    step(8'd128, 1'b1);
    chk("ovf8_set", 32'(overflow8), 1);
    chk("ovf8_locked", 32'(locked8), 0);
    chk("ovf8_period_hold", 32'(period8), 20);
    chk("ovf8_peak_max_hold", 32'(peak_max8), 255);
    idle(2);
    chk("ovf8_no_meas", 32'(mv8_cnt - base), 0);
    chk("ovf16_none", 32'(overflow), 0);
    chk("ovf16_period_hold", 32'(period), 20);

    // Async reset mid-window during a sawtooth.
    pulse_rst();
    push(256, 255, 0);
    for (int p = 0; p < 2; p++)
      for (int v = 0; v < 256; v++) step(8'(v), 1'b1);
    for (int v = 0; v <= 150; v++) step(8'(v), 1'b1);
    chk("mid_locked", 32'(locked), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_period", 32'(period), 0);
    chk("arst_peak_max", 32'(peak_max), 0);
    chk("arst_peak_min", 32'(peak_min), 32'hFF);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_meas_valid", 32'(meas_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(256, 255, 0);
    for (int v = 151; v < 256; v++) step(8'(v), 1'b1);
    for (int v = 0; v < 256; v++) step(8'(v), 1'b1);
    for (int v = 0; v <= 192; v++) step(8'(v), 1'b1);
    idle(3);

    chk("queue_drained", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
